// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master : SPI mode-0 initiator for single-byte read/write transactions.
//
// Frame is 16 bits, MSB first: {addr[6:0], rw} followed by the data byte
// (wdata for writes, 8'h00 for reads). SCLK idles low. MISO is sampled on
// rising edges. MOSI changes on falling edges.
//
// Parameters
//   CLKDIV  SCLK half-period in clk cycles (4..65535).
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             request strobe, taken only while busy=0
//   rw, addr, wdata   request fields, latched together with start
//   busy              transaction in progress
//   done              one-cycle pulse at transaction end
//   rdata             last read byte (held between reads)
//   error             write-verify mismatch flag
//   sclk, cs, mosi    SPI outputs (cs active low), all registered
//   miso              SPI input from the slave
//
// Build option
//   SPI_MASTER_WRITE_VERIFY_EN : each write is followed by a readback frame
//   of the same address. error reports readback != wdata. When the macro is
//   undefined, error is tied low.
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | cs high, waiting for start
// LEAD  | cs low, first MOSI bit set up, one half-period before rise 1
// SHIFT | SCLK toggling, 32 edges in total (rise 1 happens on entry)
// TRAIL | cs low, SCLK low, one half-period after fall 16
// GAP   | cs high for two half-periods, then done or readback frame
// ---------------------------------------------------------------------------
module spi_master #(
   parameter int unsigned CLKDIV = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       error,
   output logic       sclk,
   output logic       cs,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_TRAIL,
      S_GAP
   } state_t;

   localparam logic [15:0] HALF = 16'(CLKDIV - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q,   cnt_d;
   logic [4:0]  edge_q,  edge_d;
   logic [15:0] tx_q,    tx_d;
   logic [7:0]  cap_q,   cap_d;
   logic        rw_q,    rw_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;
   logic        cs_q,    cs_d;
   logic        sclk_q,  sclk_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        cnt_tc;

`ifdef SPI_MASTER_WRITE_VERIFY_EN
   logic [6:0]  addr_q,   addr_d;
   logic [7:0]  wdata_q,  wdata_d;
   logic        verify_q, verify_d;
   logic        error_q,  error_d;
`endif

   assign cnt_tc = (cnt_q == 16'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      cap_d   = cap_q;
      rw_d    = rw_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      rdata_d = rdata_q;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      verify_d = verify_q;
      error_d  = error_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               rw_d    = rw;
               tx_d    = {addr, rw, (rw ? 8'h00 : wdata)};
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = HALF;
               state_d = S_LEAD;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
               addr_d   = addr;
               wdata_d  = wdata;
               verify_d = 1'b0;
`endif
            end
         end

         S_LEAD: begin
            if (cnt_tc) begin
               sclk_d  = 1'b1;
               cap_d   = {cap_q[6:0], miso};
               edge_d  = 5'd1;
               cnt_d   = HALF;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         // edge_q counts SCLK edges already produced; fall 16 is edge 32.
         S_SHIFT: begin
            if (cnt_tc) begin
               cnt_d  = HALF;
               edge_d = edge_q + 5'd1;
               sclk_d = ~sclk_q;
               if (sclk_q) begin
                  // tx_q empties on the 16th shift, which parks mosi low.
                  tx_d = {tx_q[14:0], 1'b0};
                  if (edge_q == 5'd31) begin
                     edge_d  = 5'd0;
                     state_d = S_TRAIL;
                  end
               end else begin
                  cap_d = {cap_q[6:0], miso};
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         S_TRAIL: begin
            if (cnt_tc) begin
               cs_d    = 1'b1;
               cnt_d   = HALF;
               edge_d  = 5'd0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         // GAP is two half-periods; edge_q[0] marks the second one so the
         // 16-bit counter never has to hold 2*CLKDIV.
         S_GAP: begin
            if (!cnt_tc) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!edge_q[0]) begin
               edge_d = 5'd1;
               cnt_d  = HALF;
            end
`ifdef SPI_MASTER_WRITE_VERIFY_EN
            else if (!rw_q && !verify_q) begin
               verify_d = 1'b1;
               tx_d     = {addr_q, 1'b1, 8'h00};
               cs_d     = 1'b0;
               cnt_d    = HALF;
               edge_d   = 5'd0;
               state_d  = S_LEAD;
            end
`endif
            else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
               if (rw_q) begin
                  rdata_d = cap_q;
               end
`ifdef SPI_MASTER_WRITE_VERIFY_EN
               if (rw_q) begin
                  error_d = 1'b0;
               end
               if (verify_q) begin
                  rdata_d = cap_q;
                  error_d = (cap_q != wdata_q);
               end
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         edge_q  <= 5'd0;
         tx_q    <= 16'd0;
         cap_q   <= 8'h00;
         rw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         cap_q   <= cap_d;
         rw_q    <= rw_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef SPI_MASTER_WRITE_VERIFY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= 7'd0;
         wdata_q  <= 8'h00;
         verify_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         verify_q <= verify_d;
         error_q  <= error_d;
      end
   end
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign cs    = cs_q;
   assign sclk  = sclk_q;
   // tx_q is zero whenever no frame is shifting, so mosi idles low.
   assign mosi  = tx_q[15];

endmodule
